// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the sequencer FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through an external combinational ALU, with accumulator.
// Optional op counter enabled by defining ALU_SEQ_PERF_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SEQ_PERF_EN
  input  logic             op_count_clr,
  output logic [15:0]      op_count,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] acc,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holds valid and its payload stable until that edge, and ready never
  // depends combinationally on valid (both ready and rsp_valid are registered here).
  seq_state_t state;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      acc       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            alu_a     <= req_use_acc ? acc : req_a;
            alu_b     <= req_b;
            alu_sel   <= req_op;
            req_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The operands have been on the ALU for a full cycle, so its result is settled.
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
          rsp_zero  <= (alu_out == '0);
          acc       <= alu_out;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Clear wins over a simultaneous handshake; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || op_count_clr) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'd0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_use_acc = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic         alu_carry;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_carry, rsp_zero;
  logic [W-1:0] acc;
  logic [1:0]   dbg_state;
  logic         op_count_clr = 1'b0;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]  op_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] acc_m = '0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
`ifdef ALU_SEQ_PERF_EN
    .op_count_clr(op_count_clr), .op_count(op_count),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .acc(acc), .dbg_state(dbg_state)
  );

  // Reference ALU: {carry, result}
  function automatic logic [W:0] alu_model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      ALU_ADD: r = {1'b0, a} + {1'b0, b};
      ALU_SUB: r = {1'b0, a} - {1'b0, b};
      ALU_AND: r = {1'b0, a & b};
      ALU_OR:  r = {1'b0, a | b};
      ALU_XOR: r = {1'b0, a ^ b};
      ALU_SHL: r = {1'b0, a[W-2:0], 1'b0};
      ALU_SHR: r = {2'b00, a[W-1:1]};
      default: r = {1'b0, ~a};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_model(alu_sel, alu_a, alu_b);

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, follows it through EXEC/RESP and completes the response handshake.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_acc, input int stall, input logic pend_req,
                        input logic clr);
    logic [W:0]   r;
    logic [W-1:0] opa, held;
    logic [W+1:0] e;
    int n;
    opa = use_acc ? acc_m : a;
    r = alu_model(op, opa, b);
    exp_q.push_back({r[W], (r[W-1:0] == '0), r[W-1:0]});
    req_op = op; req_a = a; req_b = b; req_use_acc = use_acc; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", 32'(n < 20), 32'd1);
    tick();
    req_valid = 1'b0;
    check("exec_state", 32'(dbg_state), 32'(ST_EXEC));
    check("exec_req_ready", 32'(req_ready), 32'd0);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("alu_a", 32'(alu_a), 32'(opa));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_sel", 32'(alu_sel), 32'(op));
    tick();
    check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      if (pend_req) begin
        req_valid = 1'b1; req_op = ALU_ADD; req_a = 8'h01; req_b = 8'h01; req_use_acc = 1'b0;
      end
      tick();
      check("stall_rsp_data", 32'(rsp_data), 32'(held));
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_state", 32'(dbg_state), 32'(ST_RESP));
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    e = exp_q.pop_front();
    check("rsp_data", 32'(rsp_data), 32'(e[W-1:0]));
    check("rsp_zero", 32'(rsp_zero), 32'(e[W]));
    check("rsp_carry", 32'(rsp_carry), 32'(e[W+1]));
    check("acc", 32'(acc), 32'(e[W-1:0]));
    acc_m = e[W-1:0];
    rsp_ready = 1'b1;
    op_count_clr = clr;
    tick();
    rsp_ready = 1'b0;
    op_count_clr = 1'b0;
    check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_req_ready", 32'(req_ready), 32'd1);
    check("post_hs_state", 32'(dbg_state), 32'(ST_IDLE));
    if (pend_req) check("pend_not_accepted", 32'(alu_sel), 32'(op));
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    rst = 1'b0;
    tick();

    run_op(ALU_ADD, 8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op(ALU_SUB, 8'h03, 8'h05, 1'b0, 0, 1'b0, 1'b0);
    run_op(ALU_ADD, 8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b0);
    run_op(ALU_XOR, 8'hAA, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
`ifdef ALU_SEQ_PERF_EN
    check("op_count_4", 32'(op_count), 32'd4);
`endif
    run_op(ALU_SHL, 8'h55, 8'h00, 1'b1, 0, 1'b0, 1'b1);
`ifdef ALU_SEQ_PERF_EN
    check("op_count_clr", 32'(op_count), 32'd0);
`endif
    check("chain_acc", 32'(acc), 32'h7E);

    run_op(ALU_OR, 8'h5A, 8'h0F, 1'b0, 5, 1'b1, 1'b0);

    // Abort an operation in EXEC; nothing may come out of it.
    req_op = ALU_ADD; req_a = 8'h11; req_b = 8'h22; req_use_acc = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("abort_in_exec", 32'(dbg_state), 32'(ST_EXEC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_m = '0;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_acc", 32'(acc), 32'd0);
    begin
      int seen = 0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (rsp_valid) seen++;
      end
      rsp_ready = 1'b0;
      check("abort_no_rsp", 32'(seen), 32'd0);
    end
    run_op(ALU_ADD, 8'h99, 8'h01, 1'b1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, 1'b0);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
